// File: rtl/passcode_checker.sv
// Keypad passcode controller: buffers BCD digits, checks them against a stored
// variable-length code, supports user code change, factory restore and timed lockout.
module passcode_checker #(
  parameter int MAX_DIGITS  = 6,
  parameter int MIN_DIGITS  = 4,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 1000,
  parameter logic [MAX_DIGITS*4-1:0] DEFAULT_CODE = '0
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            key_valid_i,
  input  logic [3:0]                      key_digit_i,
  input  logic                            key_enter_i,
  input  logic                            key_clear_i,
  input  logic                            set_req_i,
  input  logic                            factory_clear_i,
  output logic                            correct_o,
  output logic                            wrong_o,
  output logic                            open_o,
  output logic                            locked_o,
  output logic                            setting_o,
  output logic                            set_done_o,
  output logic                            set_fail_o,
  output logic [$clog2(MAX_DIGITS+1)-1:0] entry_count_o
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int TW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {S_ENTRY, S_SET, S_LOCKED} state_t;

  state_t                  state_q, state_d;
  logic [MAX_DIGITS*4-1:0] buf_q, buf_d, code_q, code_d, buf_cap;
  logic [CW-1:0]           cnt_q, cnt_d, len_q, len_d, cnt_cap;
  logic [FW-1:0]           fail_q, fail_d, fail_inc;
  logic [TW-1:0]           timer_q, timer_d;
  logic open_q, open_d, locked_q, locked_d, setting_q, setting_d;
  logic correct_q, correct_d, wrong_q, wrong_d, set_done_q, set_done_d, set_fail_q, set_fail_d;
  logic match;

  assign fail_inc = fail_q + FW'(1);

  // Digits at or beyond the stored length never take part in the comparison.
  always_comb begin
    match = (cnt_q == len_q);
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < int'(len_q) && buf_q[i*4 +: 4] != code_q[i*4 +: 4]) match = 1'b0;
    end
  end

  always_comb begin
    buf_cap = buf_q;
    cnt_cap = cnt_q;
    if (key_digit_i <= 4'd9 && cnt_q < CW'(MAX_DIGITS)) begin
      for (int i = 0; i < MAX_DIGITS; i++) begin
        if (i == int'(cnt_q)) buf_cap[i*4 +: 4] = key_digit_i;
      end
      cnt_cap = cnt_q + CW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    len_d      = len_q;
    fail_d     = fail_q;
    timer_d    = timer_q;
    open_d     = open_q;
    locked_d   = locked_q;
    setting_d  = setting_q;
    correct_d  = 1'b0;
    wrong_d    = 1'b0;
    set_done_d = 1'b0;
    set_fail_d = 1'b0;
    if (factory_clear_i) begin
      state_d   = S_ENTRY;
      buf_d     = '0;
      cnt_d     = '0;
      code_d    = DEFAULT_CODE;
      len_d     = CW'(MAX_DIGITS);
      fail_d    = '0;
      timer_d   = '0;
      open_d    = 1'b0;
      locked_d  = 1'b0;
      setting_d = 1'b0;
    end else begin
      case (state_q)
        S_ENTRY: begin
          if (key_clear_i) begin
            buf_d  = '0;
            cnt_d  = '0;
            open_d = 1'b0;
          end else if (set_req_i) begin
            if (open_q) begin
              state_d   = S_SET;
              setting_d = 1'b1;
              buf_d     = '0;
              cnt_d     = '0;
            end
          end else if (key_enter_i) begin
            buf_d = '0;
            cnt_d = '0;
            if (match) begin
              correct_d = 1'b1;
              open_d    = 1'b1;
              fail_d    = '0;
            end else begin
              wrong_d = 1'b1;
              fail_d  = fail_inc;
              if (fail_inc >= FW'(MAX_FAILS)) begin
                state_d  = S_LOCKED;
                locked_d = 1'b1;
                timer_d  = TW'(LOCK_CYCLES);
                open_d   = 1'b0;
              end
            end
          end else if (key_valid_i) begin
            buf_d = buf_cap;
            cnt_d = cnt_cap;
          end
        end
        S_SET: begin
          if (key_clear_i) begin
            state_d   = S_ENTRY;
            setting_d = 1'b0;
            open_d    = 1'b0;
            buf_d     = '0;
            cnt_d     = '0;
          end else if (set_req_i) begin
            state_d = S_SET;
          end else if (key_enter_i) begin
            buf_d = '0;
            cnt_d = '0;
            if (cnt_q >= CW'(MIN_DIGITS)) begin
              code_d     = buf_q;
              len_d      = cnt_q;
              set_done_d = 1'b1;
              open_d     = 1'b0;
              setting_d  = 1'b0;
              state_d    = S_ENTRY;
            end else begin
              set_fail_d = 1'b1;
            end
          end else if (key_valid_i) begin
            buf_d = buf_cap;
            cnt_d = cnt_cap;
          end
        end
        S_LOCKED: begin
          timer_d = timer_q - TW'(1);
          if (timer_q <= TW'(1)) begin
            timer_d  = '0;
            state_d  = S_ENTRY;
            locked_d = 1'b0;
            fail_d   = '0;
          end
        end
        default: state_d = S_ENTRY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_ENTRY;
      buf_q      <= '0;
      cnt_q      <= '0;
      code_q     <= DEFAULT_CODE;
      len_q      <= CW'(MAX_DIGITS);
      fail_q     <= '0;
      timer_q    <= '0;
      open_q     <= 1'b0;
      locked_q   <= 1'b0;
      setting_q  <= 1'b0;
      correct_q  <= 1'b0;
      wrong_q    <= 1'b0;
      set_done_q <= 1'b0;
      set_fail_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      len_q      <= len_d;
      fail_q     <= fail_d;
      timer_q    <= timer_d;
      open_q     <= open_d;
      locked_q   <= locked_d;
      setting_q  <= setting_d;
      correct_q  <= correct_d;
      wrong_q    <= wrong_d;
      set_done_q <= set_done_d;
      set_fail_q <= set_fail_d;
    end
  end

  assign correct_o     = correct_q;
  assign wrong_o       = wrong_q;
  assign open_o        = open_q;
  assign locked_o      = locked_q;
  assign setting_o     = setting_q;
  assign set_done_o    = set_done_q;
  assign set_fail_o    = set_fail_q;
  assign entry_count_o = cnt_q;

endmodule

// File: tb/tb_passcode_checker.sv
// Bench for passcode_checker: expected pulse vectors are queued when a strobe is
// driven and compared against {correct, wrong, set_done, set_fail} once it registers.
module tb_passcode_checker;
  localparam int MD = 6;
  localparam int MN = 4;
  localparam int MF = 3;
  localparam int LC = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, key_valid = 1'b0, key_enter = 1'b0, key_clear = 1'b0;
  logic set_req = 1'b0, factory_clear = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic correct, wrong, open, locked, setting, set_done, set_fail;
  logic [2:0] entry_count;

  passcode_checker #(.MAX_DIGITS(MD), .MIN_DIGITS(MN), .MAX_FAILS(MF),
                     .LOCK_CYCLES(LC), .DEFAULT_CODE('0)) dut (
    .clk_i(clk), .reset_i(reset), .key_valid_i(key_valid), .key_digit_i(key_digit),
    .key_enter_i(key_enter), .key_clear_i(key_clear), .set_req_i(set_req),
    .factory_clear_i(factory_clear), .correct_o(correct), .wrong_o(wrong),
    .open_o(open), .locked_o(locked), .setting_o(setting), .set_done_o(set_done),
    .set_fail_o(set_fail), .entry_count_o(entry_count));

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] sb_q[$];
  logic [3:0] exp_p;
  wire  [3:0] pulses = {correct, wrong, set_done, set_fail};

  task automatic key(input logic [3:0] d);
    key_digit = d;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // first digit in seq[3:0]
  task automatic digits(input int n, input logic [23:0] seq);
    for (int i = 0; i < n; i++) key(seq[i*4 +: 4]);
  endtask

  // which: 0 enter, 1 clear, 2 set_req, 3 factory_clear, 4 enter+clear
  task automatic strobe(input int which, input logic [3:0] exp);
    sb_q.push_back(exp);
    case (which)
      0: key_enter = 1'b1;
      1: key_clear = 1'b1;
      2: set_req = 1'b1;
      3: factory_clear = 1'b1;
      default: begin key_enter = 1'b1; key_clear = 1'b1; end
    endcase
    @(negedge clk);
    key_enter = 1'b0; key_clear = 1'b0; set_req = 1'b0; factory_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({pulses, open, locked, setting, entry_count} !== '0) begin
      fails++;
      $display("FAIL reset_state got=%b required=0", {pulses, open, locked, setting, entry_count});
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 2; k++) begin
      strobe(0, 4'b0100);
      exp_p = sb_q.pop_front();
      checks++;
      if (pulses !== exp_p) begin
        fails++;
        $display("FAIL b2b_empty_enter%0d got=%b required=%b", k, pulses, exp_p);
      end
    end
  endtask

  task automatic test_default_code();
    digits(6, 24'h000000);
    checks++;
    if (entry_count !== 3'd6) begin
      fails++; $display("FAIL default_count got=%0d required=6", entry_count);
    end
    strobe(0, 4'b1000);
    exp_p = sb_q.pop_front();
    checks++;
    if ({pulses, open, entry_count} !== {exp_p, 1'b1, 3'd0}) begin
      fails++;
      $display("FAIL default_enter got=%b required=%b", {pulses, open, entry_count}, {exp_p, 1'b1, 3'd0});
    end
    @(negedge clk);
    checks++;
    if (pulses !== 4'b0000) begin
      fails++; $display("FAIL correct_width got=%b required=0000", pulses);
    end
  endtask

  task automatic test_set_code();
    strobe(2, 4'b0000);
    exp_p = sb_q.pop_front();
    checks++;
    if ({pulses, setting} !== {exp_p, 1'b1}) begin
      fails++; $display("FAIL set_enter got=%b required=%b", {pulses, setting}, {exp_p, 1'b1});
    end
    digits(3, 24'h000321);
    strobe(0, 4'b0001);
    exp_p = sb_q.pop_front();
    checks++;
    if ({pulses, setting, entry_count} !== {exp_p, 1'b1, 3'd0}) begin
      fails++;
      $display("FAIL set_short got=%b required=%b", {pulses, setting, entry_count}, {exp_p, 1'b1, 3'd0});
    end
    digits(4, 24'h009174);
    strobe(0, 4'b0010);
    exp_p = sb_q.pop_front();
    checks++;
    if ({pulses, open, setting} !== {exp_p, 2'b00}) begin
      fails++; $display("FAIL set_done got=%b required=%b", {pulses, open, setting}, {exp_p, 2'b00});
    end
    digits(4, 24'h009174);
    strobe(0, 4'b1000);
    exp_p = sb_q.pop_front();
    checks++;
    if (pulses !== exp_p) begin
      fails++; $display("FAIL new_code_match got=%b required=%b", pulses, exp_p);
    end
    digits(5, 24'h009174);
    strobe(0, 4'b0100);
    exp_p = sb_q.pop_front();
    checks++;
    if (pulses !== exp_p) begin
      fails++; $display("FAIL new_code_long got=%b required=%b", pulses, exp_p);
    end
  endtask

  task automatic test_lockout();
    int c0;
    int n;
    digits(4, 24'h009174);
    strobe(0, 4'b1000);
    exp_p = sb_q.pop_front();
    for (int k = 0; k < MF; k++) begin
      digits(2, 24'h000011);
      strobe(0, 4'b0100);
      exp_p = sb_q.pop_front();
      checks++;
      if ({pulses, locked} !== {exp_p, (k == MF - 1)}) begin
        fails++;
        $display("FAIL lock_wrong%0d got=%b required=%b", k, {pulses, locked}, {exp_p, (k == MF - 1)});
      end
    end
    c0 = cyc;
    checks++;
    if (open !== 1'b0) begin
      fails++; $display("FAIL lock_open got=%b required=0", open);
    end
    digits(2, 24'h000055);
    strobe(0, 4'b0000);
    exp_p = sb_q.pop_front();
    checks++;
    if ({pulses, entry_count} !== {exp_p, 3'd0}) begin
      fails++; $display("FAIL lock_ignore got=%b required=%b", {pulses, entry_count}, {exp_p, 3'd0});
    end
    n = 0;
    while (locked === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (locked !== 1'b0 || (cyc - c0) != LC) begin
      fails++;
      $display("FAIL lock_duration got=%0d cycles (locked=%b) required=%0d", cyc - c0, locked, LC);
    end
    digits(4, 24'h009174);
    strobe(0, 4'b1000);
    exp_p = sb_q.pop_front();
    checks++;
    if (pulses !== exp_p) begin
      fails++; $display("FAIL after_lock got=%b required=%b", pulses, exp_p);
    end
  endtask

  task automatic test_saturate();
    strobe(1, 4'b0000);
    exp_p = sb_q.pop_front();
    key(4'd5);
    key(4'hA);
    checks++;
    if ({pulses, open, entry_count} !== {exp_p, 1'b0, 3'd1}) begin
      fails++;
      $display("FAIL invalid_digit got=%b required=%b", {pulses, open, entry_count}, {exp_p, 1'b0, 3'd1});
    end
    for (int i = 0; i < 7; i++) key(4'd5);
    key(4'hA);
    checks++;
    if (entry_count !== 3'd6) begin
      fails++; $display("FAIL saturate got=%0d required=6", entry_count);
    end
    strobe(0, 4'b0100);
    exp_p = sb_q.pop_front();
    checks++;
    if (pulses !== exp_p) begin
      fails++; $display("FAIL saturate_enter got=%b required=%b", pulses, exp_p);
    end
  endtask

  task automatic test_enter_clear();
    digits(4, 24'h009174);
    strobe(0, 4'b1000);
    exp_p = sb_q.pop_front();
    digits(4, 24'h009174);
    strobe(4, 4'b0000);
    exp_p = sb_q.pop_front();
    checks++;
    if ({pulses, open, entry_count} !== {exp_p, 1'b0, 3'd0}) begin
      fails++;
      $display("FAIL enter_clear got=%b required=%b", {pulses, open, entry_count}, {exp_p, 1'b0, 3'd0});
    end
  endtask

  task automatic test_factory();
    for (int k = 0; k < MF; k++) begin
      digits(2, 24'h000011);
      strobe(0, 4'b0100);
      exp_p = sb_q.pop_front();
    end
    repeat (5) @(negedge clk);
    checks++;
    if (locked !== 1'b1) begin
      fails++; $display("FAIL factory_prelock got=%b required=1", locked);
    end
    strobe(3, 4'b0000);
    exp_p = sb_q.pop_front();
    checks++;
    if ({pulses, locked, setting, open, entry_count} !== {exp_p, 3'b000, 3'd0}) begin
      fails++;
      $display("FAIL factory_lock got=%b required=%b", {pulses, locked, setting, open, entry_count}, {exp_p, 6'd0});
    end
    digits(4, 24'h009174);
    strobe(0, 4'b0100);
    exp_p = sb_q.pop_front();
    checks++;
    if (pulses !== exp_p) begin
      fails++; $display("FAIL factory_old_code got=%b required=%b", pulses, exp_p);
    end
    digits(6, 24'h000000);
    strobe(0, 4'b1000);
    exp_p = sb_q.pop_front();
    checks++;
    if ({pulses, open} !== {exp_p, 1'b1}) begin
      fails++; $display("FAIL factory_default got=%b required=%b", {pulses, open}, {exp_p, 1'b1});
    end
    strobe(2, 4'b0000);
    exp_p = sb_q.pop_front();
    digits(2, 24'h000033);
    checks++;
    if ({setting, entry_count} !== {1'b1, 3'd2}) begin
      fails++; $display("FAIL set_two_digits got=%b required=%b", {setting, entry_count}, {1'b1, 3'd2});
    end
    strobe(3, 4'b0000);
    exp_p = sb_q.pop_front();
    checks++;
    if ({pulses, setting, open, entry_count} !== {exp_p, 2'b00, 3'd0}) begin
      fails++;
      $display("FAIL factory_set got=%b required=%b", {pulses, setting, open, entry_count}, {exp_p, 5'd0});
    end
    digits(6, 24'h000000);
    strobe(0, 4'b1000);
    exp_p = sb_q.pop_front();
    checks++;
    if ({pulses, open} !== {exp_p, 1'b1}) begin
      fails++; $display("FAIL factory_default2 got=%b required=%b", {pulses, open}, {exp_p, 1'b1});
    end
  endtask

  task automatic test_reset_mid();
    digits(3, 24'h000321);
    checks++;
    if ({open, entry_count} !== {1'b1, 3'd3}) begin
      fails++; $display("FAIL mid_prereset got=%b required=%b", {open, entry_count}, {1'b1, 3'd3});
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({pulses, open, locked, setting, entry_count} !== '0) begin
      fails++;
      $display("FAIL mid_reset got=%b required=0", {pulses, open, locked, setting, entry_count});
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_default_code();
    test_set_code();
    test_lockout();
    test_saturate();
    test_enter_clear();
    test_factory();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain got=%0d required=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
